// File: rtl/cpu_pkg.sv
// Shared types and constants for the 5-stage core pipeline control.
package cpu_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        StInit    = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2,
        StHalt    = 2'd3
    } state_e;

    // Architectural zero register: never a real data dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // The seven pipeline-register control outputs, in one bundle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } ctrl_t;

    // Clears every unreset pipeline register while the PC holds.
    localparam ctrl_t CtrlInit     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    // Whole pipeline frozen; MEM/WB receives a bubble so nothing retires twice.
    localparam ctrl_t CtrlFreeze   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Hold PC and IF/ID, inject a bubble into EX behind the load.
    localparam ctrl_t CtrlLoadUse  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    // Taken branch or jump: squash the wrong-path fetch.
    localparam ctrl_t CtrlRedirect = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // Free-running pipeline.
    localparam ctrl_t CtrlNormal   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    // Increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use stalls, ID-stage redirects, dmem freeze with
// timeout-to-halt, and stall/flush performance counters.
module hazard_controller
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             freeze, lu, redirect, active;
    ctrl_t            ctrl;

    assign freeze   = mem_access & ~dmem_ready;
    assign lu       = ex_mem_read & (ex_rt != REG_ZERO) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign redirect = branch_taken | jump;
    assign active   = (state_q == StRun) | (state_q == StMemWait);

    // Control outputs; in RUN/MEM_WAIT freeze beats load-use beats redirect,
    // since branch operands may still depend on the pending load.
    always_comb begin
        ctrl = CtrlInit;
        unique case (state_q)
            StInit: ctrl = CtrlInit;
            StRun, StMemWait: begin
                if (freeze) begin
                    ctrl = CtrlFreeze;
                end else if (lu) begin
                    ctrl = CtrlLoadUse;
                end else if (redirect) begin
                    ctrl = CtrlRedirect;
                end else begin
                    ctrl = CtrlNormal;
                end
            end
            StHalt: ctrl = CtrlFreeze;
            default: ctrl = CtrlInit;
        endcase
    end

    // Next state and consecutive dmem wait count.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StInit: state_d = StRun;
            StRun: begin
                if (freeze) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (!freeze) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitW'(MAX_WAIT)) begin
                    state_d = StHalt;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StInit;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_write   = ctrl.idex_write;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_write  = ctrl.exmem_write;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign halted       = (state_q == StHalt);

    // A cycle with both freeze and load-use still counts as one stall.
    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (active & (freeze | lu)),
        .count_o(stall_cnt)
    );

    // Only flushes from redirects count; INIT flushes are excluded via active.
    sat_counter #(
        .Width(CNT_W)
    ) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (active & ctrl.ifid_flush),
        .count_o(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: stimulus predicts responses from a
// behavioural model, a separate monitor compares every cycle.
module tb_hazard_controller;

    localparam int unsigned MaxWait = 4;
    localparam int unsigned CntW    = 4;
    localparam int          CntMax  = (1 << CntW) - 1;

    logic            clk;
    logic            rst_n;
    logic [4:0]      id_rs, id_rt, ex_rt;
    logic            id_uses_rt, ex_mem_read, branch_taken, jump;
    logic            mem_access, dmem_ready;
    logic            pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic            exmem_write, memwb_bubble, halted;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    hazard_controller #(
        .MAX_WAIT(MaxWait),
        .CNT_W   (CntW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .branch_taken(branch_taken),
        .jump        (jump),
        .mem_access  (mem_access),
        .dmem_ready  (dmem_ready),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_write  (idex_write),
        .idex_bubble (idex_bubble),
        .exmem_write (exmem_write),
        .memwb_bubble(memwb_bubble),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected: {7 control bits, halted, stall_cnt, flush_cnt}.
    typedef logic [7+1+CntW+CntW-1:0] exp_t;
    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   stim_done   = 1'b0;

    // Behavioural model: in_init marks the single post-reset cycle, waits
    // counts consecutive frozen cycles, halt is sticky once waits > MaxWait.
    bit m_init   = 1'b1;
    bit m_halted = 1'b0;
    int m_waits  = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    function automatic int sat_inc(input int v);
        return (v >= CntMax) ? CntMax : v + 1;
    endfunction

    // Apply one cycle of inputs and push the predicted response.
    task automatic drive(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                         input bit uses_rt, input bit mr, input logic [4:0] ert,
                         input bit bt, input bit jmp, input bit ma, input bit dr);
        logic [6:0] c;
        bit         h;
        bit         frz, ldu, rdr;
        @(posedge clk);
        #1;
        rst_n        = rst;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = uses_rt;
        ex_mem_read  = mr;
        ex_rt        = ert;
        branch_taken = bt;
        jump         = jmp;
        mem_access   = ma;
        dmem_ready   = dr;
        frz = ma && !dr;
        ldu = mr && (ert != 5'd0) && ((ert == rs) || (uses_rt && (ert == rt)));
        rdr = bt || jmp;
        h   = 1'b0;
        if (!rst) begin
            m_init   = 1'b1;
            m_halted = 1'b0;
            m_waits  = 0;
            m_stall  = 0;
            m_flush  = 0;
            exp_q.push_back({7'b0111111, 1'b0, CntW'(0), CntW'(0)});
        end else if (m_init) begin
            exp_q.push_back({7'b0111111, 1'b0, CntW'(m_stall), CntW'(m_flush)});
            m_init = 1'b0;
        end else if (m_halted) begin
            exp_q.push_back({7'b0000001, 1'b1, CntW'(m_stall), CntW'(m_flush)});
        end else begin
            if (frz)      c = 7'b0000001;
            else if (ldu) c = 7'b0001110;
            else if (rdr) c = 7'b1111010;
            else          c = 7'b1101010;
            exp_q.push_back({c, h, CntW'(m_stall), CntW'(m_flush)});
            if (frz || ldu) m_stall = sat_inc(m_stall);
            if (!frz && !ldu && rdr) m_flush = sat_inc(m_flush);
            if (frz) begin
                m_waits++;
                if (m_waits > int'(MaxWait)) m_halted = 1'b1;
            end else begin
                m_waits = 0;
            end
        end
    endtask

    task automatic nop();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                       exmem_write, memwb_bubble, halted, stall_cnt, flush_cnt};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL cycle %0d ctrl/halt/stall/flush: got %b/%b/%0d/%0d exp %b/%b/%0d/%0d",
                             vectors, got[15:9], got[8], got[7:4], got[3:0],
                             e[15:9], e[8], e[7:4], e[3:0]);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = '0; branch_taken = 1'b0; jump = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;

        // Reset, one INIT cycle, then RUN.
        do_reset();
        do_reset();
        repeat (3) nop();

        // Load-use on rs, then ex_rt == 0 (never stalls), then via rt.
        drive(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        nop();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        nop();

        // Taken branch, jump, then branch masked by load-use.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        nop();

        // Three wait cycles, then completion together with a branch.
        repeat (3) drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        nop();

        // Timeout into HALT, sticky after dmem_ready returns, cleared by reset.
        repeat (8) drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        do_reset();
        repeat (2) nop();

        // Counter saturation: 20 load-use cycles and 20 redirects.
        repeat (20) drive(1'b1, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2) nop();

        // Randomized traffic with small register indices to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) < 3));
        end
        nop();
        stim_done = 1'b1;
    end

    // Drain the scoreboard, then summarise; bounded so it always ends.
    initial begin
        int budget;
        budget = 20000;
        while (!stim_done && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (2) @(negedge clk);
        if (!stim_done || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: stimulus done %0d, %0d expected responses left, want 1 and 0",
                     stim_done, exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
